// File: rtl/mac_stream_accumulator_if.sv
// ---------------------------------------------------------------------------
// mac_stream_accumulator_if
//   Bundles the operand stream (valid/ready with last marker and abort) and
//   the result stream (valid/ready) of mac_stream_accumulator.
//   master : producer of operand beats and consumer of results
//   slave  : the accumulator itself
// Signals
//   in_valid/in_ready/in_a/in_b/in_last : operand beat handshake and payload
//   abort                               : drop the vector in progress
//   out_valid/out_ready                 : result handshake
//   out_acc/out_count/out_ovf           : result, beat count, overflow flag
// ---------------------------------------------------------------------------
interface mac_stream_accumulator_if #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic             in_last;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, abort, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, abort, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/mac_stream_accumulator.sv
// ---------------------------------------------------------------------------
// mac_stream_accumulator
//   Two-stage pipelined multiply-accumulate engine. Each accepted beat is
//   multiplied in stage P and added into a per-vector accumulator in stage A.
//   The beat flagged in_last closes the vector: its final sum, beat count and
//   sticky overflow flag are loaded into the result register and presented on
//   a valid/ready output. Signed or unsigned operands; saturating or wrapping
//   accumulation.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active high
//   bus  : slave side of mac_stream_accumulator_if (operand and result streams)
// ---------------------------------------------------------------------------
module mac_stream_accumulator #(
  parameter int A_W      = 8,
  parameter int B_W      = 8,
  parameter int ACC_W    = 20,
  parameter int CNT_W    = 8,
  parameter bit SIGNED   = 1'b0,
  parameter bit SATURATE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  mac_stream_accumulator_if.slave   bus
);

  localparam int P_W = A_W + B_W;

  if (ACC_W < P_W) begin : g_acc_w_check
    $error("mac_stream_accumulator: ACC_W must be >= A_W+B_W");
  end

  typedef enum logic {S_FIRST, S_ACCUM} state_t;

  state_t           state;
  logic             p_valid;
  logic             p_last;
  logic [P_W-1:0]   prod_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic             stall;
  logic             in_fire;
  logic [P_W-1:0]   a_ext;
  logic [P_W-1:0]   b_ext;
  logic [P_W-1:0]   prod_d;

  // Result stage holds while its consumer is not ready; abort blocks intake
  // so the discarded vector cannot leak a beat into the next one.
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~rst & ~stall & ~bus.abort;
  assign in_fire      = bus.in_valid & bus.in_ready;

  // Extending both operands to the product width and keeping the low P_W
  // bits of the product gives the correct two's complement or unsigned result.
  assign a_ext  = {{B_W{SIGNED & bus.in_a[A_W-1]}}, bus.in_a};
  assign b_ext  = {{A_W{SIGNED & bus.in_b[B_W-1]}}, bus.in_b};
  assign prod_d = a_ext * b_ext;

  // Stage A arithmetic, one guard bit wider than the accumulator.
  logic [ACC_W:0]   prod_x;
  logic [ACC_W:0]   base_x;
  logic [ACC_W:0]   sum_x;
  logic             ovf_now;
  logic [ACC_W-1:0] sum_sel;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;
  logic             first;

  assign first = (state == S_FIRST);

  // NOTE: every signal assigned in always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    prod_x   = {{(ACC_W + 1 - P_W){SIGNED & prod_q[P_W-1]}}, prod_q};
    base_x   = first ? '0 : {SIGNED & acc_q[ACC_W-1], acc_q};
    sum_x    = base_x + prod_x;
    ovf_now  = 1'b0;
    sum_sel  = sum_x[ACC_W-1:0];

    if (SIGNED) begin
      // Same-sign operands whose sum changes sign have overflowed.
      ovf_now = (base_x[ACC_W-1] == prod_x[ACC_W-1]) &&
                (sum_x[ACC_W-1] != base_x[ACC_W-1]);
      if (SATURATE && ovf_now) begin
        sum_sel = prod_x[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      ovf_now = sum_x[ACC_W];
      if (SATURATE && ovf_now) begin
        sum_sel = '1;
      end
    end

    ovf_next = ovf_now | (~first & ovf_q);

    if (first) begin
      cnt_next = CNT_W'(1);
    end else if (cnt_q == '1) begin
      cnt_next = cnt_q;
    end else begin
      cnt_next = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_FIRST;
      p_valid       <= 1'b0;
      p_last        <= 1'b0;
      prod_q        <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_acc   <= '0;
      bus.out_count <= '0;
      bus.out_ovf   <= 1'b0;
    end else begin
      // Consumed results drop; a result loaded below on the same edge wins.
      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (bus.abort) begin
        // The result register is left alone; only the vector in flight goes.
        p_valid <= 1'b0;
        state   <= S_FIRST;
        acc_q   <= '0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else if (!stall) begin
        p_valid <= in_fire;
        if (in_fire) begin
          prod_q <= prod_d;
          p_last <= bus.in_last;
        end

        if (p_valid) begin
          if (p_last) begin
            state         <= S_FIRST;
            bus.out_valid <= 1'b1;
            bus.out_acc   <= sum_sel;
            bus.out_count <= cnt_next;
            bus.out_ovf   <= ovf_next;
          end else begin
            state <= S_ACCUM;
            acc_q <= sum_sel;
            cnt_q <= cnt_next;
            ovf_q <= ovf_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_stream_accumulator.sv
// ---------------------------------------------------------------------------
// tb_mac_stream_accumulator
//   Four accumulator configurations share one stimulus driver:
//     dut0 : unsigned, ACC_W=20, saturating
//     dut1 : unsigned, ACC_W=16, saturating
//     dut2 : unsigned, ACC_W=16, wrapping
//     dut3 : signed,   ACC_W=20, saturating
//   Each beat goes to the DUTs selected by a mask. Expected results are
//   pushed per DUT when a vector is issued; one monitor per DUT pops and
//   compares whenever a result is handed over.
// ---------------------------------------------------------------------------
module tb_mac_stream_accumulator;

  typedef struct {
    logic [19:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[4][$];

  mac_stream_accumulator_if #(.ACC_W(20)) b0 ();
  mac_stream_accumulator_if #(.ACC_W(16)) b1 ();
  mac_stream_accumulator_if #(.ACC_W(16)) b2 ();
  mac_stream_accumulator_if #(.ACC_W(20)) b3 ();

  mac_stream_accumulator #(.ACC_W(20), .SIGNED(1'b0), .SATURATE(1'b1))
    dut0 (.clk(clk), .rst(rst), .bus(b0));
  mac_stream_accumulator #(.ACC_W(16), .SIGNED(1'b0), .SATURATE(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  mac_stream_accumulator #(.ACC_W(16), .SIGNED(1'b0), .SATURATE(1'b0))
    dut2 (.clk(clk), .rst(rst), .bus(b2));
  mac_stream_accumulator #(.ACC_W(20), .SIGNED(1'b1), .SATURATE(1'b1))
    dut3 (.clk(clk), .rst(rst), .bus(b3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input logic [19:0] acc, input logic [7:0] cnt, input logic ovf);
    exp_t e;
    e.acc = acc;
    e.cnt = cnt;
    e.ovf = ovf;
    sb[idx].push_back(e);
  endtask

  task automatic mon(input int idx, input logic [19:0] acc, input logic [7:0] cnt, input logic ovf);
    exp_t e;
    if (sb[idx].size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_result dut%0d: acc=0x%0h count=%0d with nothing expected", idx, acc, cnt);
    end else begin
      e = sb[idx].pop_front();
      check($sformatf("dut%0d_acc", idx), 32'(acc), 32'(e.acc));
      check($sformatf("dut%0d_count", idx), 32'(cnt), 32'(e.cnt));
      check($sformatf("dut%0d_ovf", idx), 32'(ovf), 32'(e.ovf));
    end
  endtask

  // Monitors: outputs are sampled on the falling edge, away from updates.
  always @(negedge clk) if (!rst && b0.out_valid && b0.out_ready) mon(0, b0.out_acc, b0.out_count, b0.out_ovf);
  always @(negedge clk) if (!rst && b1.out_valid && b1.out_ready) mon(1, {4'b0, b1.out_acc}, b1.out_count, b1.out_ovf);
  always @(negedge clk) if (!rst && b2.out_valid && b2.out_ready) mon(2, {4'b0, b2.out_acc}, b2.out_count, b2.out_ovf);
  always @(negedge clk) if (!rst && b3.out_valid && b3.out_ready) mon(3, b3.out_acc, b3.out_count, b3.out_ovf);

  // Drive one beat to every DUT in mask and wait until all of them take it.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last, input logic [3:0] mask);
    int waited = 0;
    b0.in_a = a; b1.in_a = a; b2.in_a = a; b3.in_a = a;
    b0.in_b = b; b1.in_b = b; b2.in_b = b; b3.in_b = b;
    b0.in_last = last; b1.in_last = last; b2.in_last = last; b3.in_last = last;
    b0.in_valid = mask[0]; b1.in_valid = mask[1];
    b2.in_valid = mask[2]; b3.in_valid = mask[3];
    forever begin
      @(negedge clk);
      if ((!mask[0] || b0.in_ready) && (!mask[1] || b1.in_ready) &&
          (!mask[2] || b2.in_ready) && (!mask[3] || b3.in_ready)) break;
      waited++;
      if (waited > 200) begin
        check("send_timeout", 32'(waited), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0; b1.in_valid = 1'b0; b2.in_valid = 1'b0; b3.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] hold_acc;
    logic [7:0]  hold_cnt;

    b0.in_valid = 0; b1.in_valid = 0; b2.in_valid = 0; b3.in_valid = 0;
    b0.in_a = 0; b1.in_a = 0; b2.in_a = 0; b3.in_a = 0;
    b0.in_b = 0; b1.in_b = 0; b2.in_b = 0; b3.in_b = 0;
    b0.in_last = 0; b1.in_last = 0; b2.in_last = 0; b3.in_last = 0;
    b0.abort = 0; b1.abort = 0; b2.abort = 0; b3.abort = 0;
    b0.out_ready = 1; b1.out_ready = 1; b2.out_ready = 1; b3.out_ready = 1;

    // Reset state
    #12;
    check("rst_in_ready", 32'(b0.in_ready), 32'd0);
    check("rst_out_valid", 32'(b0.out_valid), 32'd0);
    check("rst_out_acc", 32'(b0.out_acc), 32'd0);
    check("rst_out_count", 32'(b0.out_count), 32'd0);
    check("rst_out_ovf", 32'(b0.out_ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // T1: 12+30+56 = 98, with latency check (valid two cycles after last accept, one cycle long)
    push(0, 20'd98, 8'd3, 1'b0);
    send(8'd3, 8'd4, 1'b0, 4'b0001);
    send(8'd5, 8'd6, 1'b0, 4'b0001);
    send(8'd7, 8'd8, 1'b1, 4'b0001);
    @(negedge clk); check("t1_valid_n1", 32'(b0.out_valid), 32'd0);
    @(negedge clk); check("t1_valid_n2", 32'(b0.out_valid), 32'd1);
    @(negedge clk); check("t1_valid_n3", 32'(b0.out_valid), 32'd0);
    idle(2);

    // T2: 65025*2 = 130050 overflows 16 bits: clamp 65535 / wrap 64514
    push(1, 20'd65535, 8'd2, 1'b1);
    push(2, 20'd64514, 8'd2, 1'b1);
    send(8'd255, 8'd255, 1'b0, 4'b0110);
    send(8'd255, 8'd255, 1'b1, 4'b0110);
    idle(4);

    // Overflow flag stays set for the rest of the vector after wrapping
    push(2, 20'd64515, 8'd3, 1'b1);
    send(8'd255, 8'd255, 1'b0, 4'b0100);
    send(8'd255, 8'd255, 1'b0, 4'b0100);
    send(8'd1, 8'd1, 1'b1, 4'b0100);
    // Overflow flag is per vector: a clean vector reports 0
    push(1, 20'd6, 8'd1, 1'b0);
    send(8'd2, 8'd3, 1'b1, 4'b0010);
    idle(4);

    // T3: signed -3*5 + (-128)*(-128) = 16369
    push(3, 20'h03FF1, 8'd2, 1'b0);
    send(8'hFD, 8'h05, 1'b0, 4'b1000);
    send(8'h80, 8'h80, 1'b1, 4'b1000);
    // Signed single-beat negative result: -1*1
    push(3, 20'hFFFFF, 8'd1, 1'b0);
    send(8'hFF, 8'h01, 1'b1, 4'b1000);
    idle(4);

    // Unsigned 20-bit clamp: 17 * 65025 = 1105425 > 1048575
    push(0, 20'hFFFFF, 8'd17, 1'b1);
    for (int i = 0; i < 17; i++) send(8'd255, 8'd255, (i == 16), 4'b0001);
    idle(4);

    // Beat counter saturates at 255 over a 260-beat vector
    push(0, 20'd0, 8'd255, 1'b0);
    for (int i = 0; i < 260; i++) send(8'd0, 8'd7, (i == 259), 4'b0001);
    idle(4);

    // T4: result A held with out_ready low while vector B streams in
    push(0, 20'd44, 8'd3, 1'b0);
    push(0, 20'd500, 8'd2, 1'b0);
    b0.out_ready = 1'b0;
    fork
      begin
        send(8'd1, 8'd2, 1'b0, 4'b0001);
        send(8'd3, 8'd4, 1'b0, 4'b0001);
        send(8'd5, 8'd6, 1'b1, 4'b0001);
        send(8'd10, 8'd10, 1'b0, 4'b0001);
        send(8'd20, 8'd20, 1'b1, 4'b0001);
      end
      begin
        int w = 0;
        while (!b0.out_valid && w < 50) begin
          @(negedge clk);
          w++;
        end
        check("t4_valid_seen", 32'(b0.out_valid), 32'd1);
        hold_acc = b0.out_acc;
        hold_cnt = b0.out_count;
        check("t4_held_acc", 32'(hold_acc), 32'd44);
        repeat (5) begin
          @(negedge clk);
          check("t4_in_ready_stall", 32'(b0.in_ready), 32'd0);
          check("t4_acc_stable", 32'(b0.out_acc), 32'(hold_acc));
          check("t4_count_stable", 32'(b0.out_count), 32'(hold_cnt));
          check("t4_valid_held", 32'(b0.out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        b0.out_ready = 1'b1;
      end
    join
    idle(5);

    // T5: partial vector aborted, next vector stands alone
    push(0, 20'd4, 8'd1, 1'b0);
    send(8'd9, 8'd9, 1'b0, 4'b0001);
    send(8'd9, 8'd9, 1'b0, 4'b0001);
    b0.abort = 1'b1;
    @(negedge clk);
    check("t5_in_ready_abort", 32'(b0.in_ready), 32'd0);
    @(posedge clk);
    #1;
    b0.abort = 1'b0;
    send(8'd2, 8'd2, 1'b1, 4'b0001);
    idle(4);

    // T6: asynchronous reset mid-vector clears the held result at once
    check("t6_pre_acc", 32'(b0.out_acc), 32'd4);
    send(8'd5, 8'd5, 1'b0, 4'b0001);
    send(8'd6, 8'd6, 1'b0, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_out_acc", 32'(b0.out_acc), 32'd0);
    check("t6_rst_out_count", 32'(b0.out_count), 32'd0);
    check("t6_rst_in_ready", 32'(b0.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    push(0, 20'd1, 8'd1, 1'b0);
    send(8'd1, 8'd1, 1'b1, 4'b0001);
    idle(8);

    for (int i = 0; i < 4; i++) check($sformatf("sb%0d_drained", i), 32'(sb[i].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
